// File: rtl/alarm_chime_ctrl_pkg.sv
// Shared types, tone encodings and BCD validation helpers for the alarm/chime controller.
package alarm_chime_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHIME  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    localparam logic [1:0] TONE_OFF   = 2'b00;
    localparam logic [1:0] TONE_CHIME = 2'b01;
    localparam logic [1:0] TONE_ALARM = 2'b10;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

    // With all four digits legal BCD, a plain byte compare doubles as a numeric range check.
    function automatic logic alarm_valid(input logic [7:0] hh, input logic [7:0] mm);
        return bcd_valid(hh[7:4]) && bcd_valid(hh[3:0]) &&
               bcd_valid(mm[7:4]) && bcd_valid(mm[3:0]) &&
               (hh <= 8'h23) && (mm <= 8'h59);
    endfunction

endpackage

// File: rtl/alarm_chime_ctrl_tick_countdown.sv
// Saturating tick counter shared by every timed state; done flags the tick that reaches limit.
module tick_countdown #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic          done
);

    logic [CW-1:0] count_r;
    logic [CW:0]   next_s;

    assign next_s = {1'b0, count_r} + {{CW{1'b0}}, 1'b1};
    assign done   = (next_s >= {1'b0, limit});

    // Count register: clear wins, otherwise advance on enabled ticks and hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (en && (count_r != {CW{1'b1}})) begin
            count_r <= next_s[CW-1:0];
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/alarm_chime_ctrl.sv
// Hourly chime and single-alarm ring/snooze controller driving the beeper tone request.
module alarm_chime_ctrl
    import alarm_chime_ctrl_pkg::*;
#(
    parameter int CHIME_SECS  = 2,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [3:0] hour_t,
    input  logic [3:0] hour_o,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    input  logic       alarm_en,
    input  logic       alarm_load,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       snooze,
    input  logic       stop,
    output logic [1:0] bee_req,
    output logic       alarm_active,
    output logic [7:0] alarm_hh_q,
    output logic [7:0] alarm_mm_q,
    output logic       load_err
);

    localparam int MAX_CR   = (CHIME_SECS > RING_SECS) ? CHIME_SECS : RING_SECS;
    localparam int MAX_SECS = (MAX_CR > SNOOZE_SECS) ? MAX_CR : SNOOZE_SECS;
    localparam int CW       = $clog2(MAX_SECS) + 1;
    localparam int SW       = $clog2(MAX_SNOOZE + 1);

    state_t        state_r, state_s;
    logic          beep_ph_r, beep_ph_s;
    logic [SW-1:0] snooze_cnt_r, snooze_cnt_s;
    logic          cnt_clear_s, cnt_en_s, cnt_done_s;
    logic [CW-1:0] limit_s;
    logic [1:0]    bee_s;
    logic          sec_zero_s, alarm_hit_s, chime_hit_s;

    assign sec_zero_s  = tick_1hz && (sec_t == 4'd0) && (sec_o == 4'd0);
    assign alarm_hit_s = sec_zero_s && alarm_en &&
                         ({hour_t, hour_o} == alarm_hh_q) && ({min_t, min_o} == alarm_mm_q);
    assign chime_hit_s = sec_zero_s && (min_t == 4'd0) && (min_o == 4'd0);

    tick_countdown #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear_s),
        .en    (cnt_en_s),
        .limit (limit_s),
        .done  (cnt_done_s)
    );

    // Next-state, counter control and tone selection; tone follows the state being entered.
    always_comb begin
        state_s      = state_r;
        beep_ph_s    = beep_ph_r;
        snooze_cnt_s = snooze_cnt_r;
        cnt_clear_s  = 1'b0;
        cnt_en_s     = 1'b0;
        limit_s      = CW'(CHIME_SECS);
        bee_s        = TONE_OFF;
        case (state_r)
            IDLE: begin
                if (alarm_hit_s) begin
                    state_s      = RING;
                    beep_ph_s    = 1'b1;
                    snooze_cnt_s = '0;
                    cnt_clear_s  = 1'b1;
                end else if (chime_hit_s) begin
                    state_s     = CHIME;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CHIME: begin
                limit_s = CW'(CHIME_SECS);
                if (alarm_hit_s) begin
                    state_s      = RING;
                    beep_ph_s    = 1'b1;
                    snooze_cnt_s = '0;
                    cnt_clear_s  = 1'b1;
                end else if (tick_1hz && cnt_done_s) begin
                    state_s = IDLE;
                end else if (tick_1hz) begin
                    cnt_en_s = 1'b1;
                end else begin
                    state_s = CHIME;
                end
            end
            RING: begin
                limit_s = CW'(RING_SECS);
                if (!alarm_en || stop) begin
                    state_s = IDLE;
                end else if (snooze) begin
                    if (snooze_cnt_r < SW'(MAX_SNOOZE)) begin
                        state_s      = SNOOZE;
                        snooze_cnt_s = snooze_cnt_r + SW'(1);
                        cnt_clear_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (tick_1hz && cnt_done_s) begin
                    state_s = IDLE;
                end else if (tick_1hz) begin
                    cnt_en_s  = 1'b1;
                    beep_ph_s = ~beep_ph_r;
                end else begin
                    state_s = RING;
                end
            end
            SNOOZE: begin
                limit_s = CW'(SNOOZE_SECS);
                if (!alarm_en || stop) begin
                    state_s = IDLE;
                end else if (tick_1hz && cnt_done_s) begin
                    state_s     = RING;
                    beep_ph_s   = 1'b1;
                    cnt_clear_s = 1'b1;
                end else if (tick_1hz) begin
                    cnt_en_s = 1'b1;
                end else begin
                    state_s = SNOOZE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s == CHIME) begin
            bee_s = TONE_CHIME;
        end else if ((state_s == RING) && beep_ph_s) begin
            bee_s = TONE_ALARM;
        end else begin
            bee_s = TONE_OFF;
        end
    end

    // FSM state and registered tone/activity outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            beep_ph_r    <= 1'b0;
            snooze_cnt_r <= '0;
            bee_req      <= TONE_OFF;
            alarm_active <= 1'b0;
        end else begin
            state_r      <= state_s;
            beep_ph_r    <= beep_ph_s;
            snooze_cnt_r <= snooze_cnt_s;
            bee_req      <= bee_s;
            alarm_active <= (state_s == RING) || (state_s == SNOOZE);
        end
    end

    // Alarm time storage; a rejected load keeps the old time and pulses load_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hh_q <= 8'h00;
            alarm_mm_q <= 8'h00;
            load_err   <= 1'b0;
        end else if (alarm_load && alarm_valid(alarm_hh, alarm_mm)) begin
            alarm_hh_q <= alarm_hh;
            alarm_mm_q <= alarm_mm;
            load_err   <= 1'b0;
        end else if (alarm_load) begin
            load_err   <= 1'b1;
        end else begin
            load_err   <= 1'b0;
        end
    end

endmodule
